// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver that assembles WORD_COUNT characters into one wide word with parity/framing/timeout status
module uart_rx_frame #(
  parameter int         CLK_RATE     = 10000000,
  parameter int         BAUD_RATE    = 115200,
  parameter int         WORD_LEN     = 8,
  parameter int         WORD_COUNT   = 8,
  parameter logic [7:0] PARITY       = "L",
  parameter int         STOP         = 1,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_i,
  output logic [WORD_LEN*WORD_COUNT-1:0] rx_data_o,
  output logic                           rx_valid_o,
  output logic                           rx_perr_o,
  output logic                           rx_ferr_o,
  output logic                           rx_timeout_o,
  output logic                           rx_busy_o
);
  localparam int DIV     = CLK_RATE / BAUD_RATE;
  localparam int HALF    = DIV / 2;
  localparam int GAP_CYC = TIMEOUT_BITS * DIV;
  localparam int CW      = $clog2(DIV + 1);
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam int IW      = $clog2(WORD_COUNT + 1);
  localparam int FW      = WORD_LEN * WORD_COUNT;
  localparam bit HAS_PAR = PARITY != "N";

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP, S_WAIT_HIGH} state_t;

  state_t              state, state_nxt;
  logic                rx_meta, rxs;
  logic [CW-1:0]       cnt;
  logic [GW-1:0]       gcnt;
  logic [3:0]          bcnt;
  logic [IW-1:0]       idx;
  logic [WORD_LEN-1:0] shreg;
  logic [FW-1:0]       slots, assembled;
  logic                perr_sticky, par_exp;
  logic                tick, start_det, start_ok, data_smp, par_smp;
  logic                ferr_ev, stop_done, finish, tout_ev;

  // two-flop synchroniser on the asynchronous line, idle-high out of reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {rx_meta, rxs} <= 2'b11;
    else {rx_meta, rxs} <= {rx_i, rx_meta};

  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= S_IDLE;
    else state <= state_nxt;

  // next-state logic; a false start mid-frame falls back to GAP so the gap timer keeps running
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rxs) state_nxt = S_START;
      S_START:     if (tick) state_nxt = rxs ? (idx != '0 ? S_GAP : S_IDLE) : S_DATA;
      S_DATA:      if (tick && bcnt == 4'(WORD_LEN - 1)) state_nxt = HAS_PAR ? S_PAR : S_STOP;
      S_PAR:       if (tick) state_nxt = S_STOP;
      S_STOP:      if (ferr_ev) state_nxt = S_WAIT_HIGH;
                   else if (stop_done) state_nxt = finish ? S_IDLE : S_GAP;
      S_GAP:       if (!rxs) state_nxt = S_START;
                   else if (tout_ev) state_nxt = S_IDLE;
      S_WAIT_HIGH: if (rxs) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // per-state control events and the frame image with the current character dropped into its slot
  always_comb begin
    tick      = cnt == '0;
    start_det = (state == S_IDLE || state == S_GAP) && !rxs;
    start_ok  = state == S_START && tick && !rxs;
    data_smp  = state == S_DATA && tick;
    par_smp   = state == S_PAR && tick;
    ferr_ev   = state == S_STOP && tick && !rxs;
    stop_done = state == S_STOP && tick && rxs && bcnt == 4'(STOP - 1);
    finish    = stop_done && idx == IW'(WORD_COUNT - 1);
    tout_ev   = state == S_GAP && rxs && gcnt == '0;
    par_exp   = PARITY == "E" ? ^shreg : PARITY == "O" ? ~^shreg : PARITY == "H";
    assembled = slots;
    assembled[int'(idx) * WORD_LEN +: WORD_LEN] = shreg;
  end

  // bit timing, shift register, slot storage, gap timer and sticky parity flag
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt         <= '0;
      gcnt        <= '0;
      bcnt        <= '0;
      idx         <= '0;
      shreg       <= '0;
      slots       <= '0;
      perr_sticky <= 1'b0;
    end else begin
      if (start_det) cnt <= CW'(HALF - 1);
      else if (state inside {S_START, S_DATA, S_PAR, S_STOP}) cnt <= tick ? CW'(DIV - 1) : cnt - CW'(1);
      if (start_ok || par_smp) bcnt <= '0;
      else if (data_smp) bcnt <= bcnt == 4'(WORD_LEN - 1) ? '0 : bcnt + 4'd1;
      else if (state == S_STOP && tick && rxs) bcnt <= bcnt + 4'd1;
      if (data_smp) shreg <= {rxs, shreg[WORD_LEN-1:1]};
      if (finish || ferr_ev || tout_ev) idx <= '0;
      else if (stop_done) idx <= idx + IW'(1);
      if (stop_done) slots <= assembled;
      if (stop_done) gcnt <= GW'(GAP_CYC - 1);
      else if (state == S_GAP && gcnt != '0) gcnt <= gcnt - GW'(1);
      if (finish || ferr_ev || tout_ev) perr_sticky <= 1'b0;
      else if (par_smp && rxs != par_exp) perr_sticky <= 1'b1;
    end

  // registered outputs: status pulses, frame publish and busy flag
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_perr_o    <= 1'b0;
      rx_ferr_o    <= 1'b0;
      rx_timeout_o <= 1'b0;
      rx_busy_o    <= 1'b0;
    end else begin
      rx_valid_o   <= finish;
      rx_ferr_o    <= ferr_ev;
      rx_timeout_o <= tout_ev;
      if (finish) rx_data_o <= assembled;
      if (finish) rx_perr_o <= perr_sticky;
      if (start_ok) rx_busy_o <= 1'b1;
      else if (finish || ferr_ev || tout_ev) rx_busy_o <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed self-checking bench for uart_rx_frame at default parameters
`timescale 1ns/1ps
module tb_uart_rx_frame;
  localparam logic [63:0] F1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] F2 = 64'hFEDCBA9876543210;
  localparam logic [63:0] F3 = 64'hDEADBEEFCAFEF00D;
  localparam int BC = 86;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [63:0] rx_data;
  logic        rx_valid, rx_perr, rx_ferr, rx_timeout, rx_busy;
  int          checks = 0;
  int          fails = 0;
  int          vcnt = 0, fcnt = 0, tcnt = 0, cyc = 0, tout_cyc = 0, viol = 0;
  logic [63:0] v_data = '0;
  logic        v_perr = 1'b0, v_busy = 1'b0, busy_seen = 1'b0;
  logic        p_valid = 1'b0, p_ferr = 1'b0, p_tout = 1'b0;

  uart_rx_frame dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_i(rx),
    .rx_data_o(rx_data),
    .rx_valid_o(rx_valid),
    .rx_perr_o(rx_perr),
    .rx_ferr_o(rx_ferr),
    .rx_timeout_o(rx_timeout),
    .rx_busy_o(rx_busy)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc++;

  // pulse monitor sampled on the falling edge, also tracks exclusivity and single-cycle width
  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt++;
      v_data = rx_data;
      v_perr = rx_perr;
      v_busy = rx_busy;
    end
    if (rx_ferr) fcnt++;
    if (rx_timeout) begin
      tcnt++;
      tout_cyc = cyc;
    end
    if (rx_busy) busy_seen = 1'b1;
    if (int'(rx_valid) + int'(rx_ferr) + int'(rx_timeout) > 1) viol++;
    if ((rx_valid && p_valid) || (rx_ferr && p_ferr) || (rx_timeout && p_tout)) viol++;
    p_valid = rx_valid;
    p_ferr  = rx_ferr;
    p_tout  = rx_timeout;
  end

  task automatic bit_out(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par, input logic stp, input int bc);
    bit_out(1'b0, bc);
    for (int i = 0; i < 8; i++) bit_out(b[i], bc);
    bit_out(par, bc);
    bit_out(stp, bc);
  endtask

  task automatic send_frame(input logic [63:0] d, input int bad, input int bc);
    for (int k = 0; k < 8; k++) send_byte(d[8*k +: 8], k == bad, 1'b1, bc);
  endtask

  task automatic test_reset;
    int v0;
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, rx_perr, rx_ferr, rx_timeout, rx_busy} !== 69'd0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h v=%b p=%b f=%b t=%b b=%b, expected all 0", rx_data, rx_valid, rx_perr, rx_ferr, rx_timeout, rx_busy);
    end
    rst = 1'b0;
    v0 = vcnt + fcnt + tcnt;
    bit_out(1'b1, 3 * BC);
    checks++;
    if (vcnt + fcnt + tcnt != v0 || rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_quiet: got pulses=%0d busy=%b, expected 0 and 0", vcnt + fcnt + tcnt - v0, rx_busy);
    end
  endtask

  task automatic test_clean;
    int v0;
    v0 = vcnt;
    send_frame(F1, -1, BC);
    bit_out(1'b1, 20);
    checks++;
    if (vcnt - v0 != 1) begin fails++; $display("FAIL clean_valid_count: got %0d, expected 1", vcnt - v0); end
    checks++;
    if (v_data !== F1) begin fails++; $display("FAIL clean_data: got %h, expected %h", v_data, F1); end
    checks++;
    if (v_perr !== 1'b0) begin fails++; $display("FAIL clean_perr: got %b, expected 0", v_perr); end
    checks++;
    if (v_busy !== 1'b0) begin fails++; $display("FAIL clean_busy_at_valid: got %b, expected 0", v_busy); end
    checks++;
    if (rx_data !== F1) begin fails++; $display("FAIL clean_data_hold: got %h, expected %h", rx_data, F1); end
  endtask

  task automatic test_parity;
    int v0;
    v0 = vcnt;
    send_frame(F1, 3, BC);
    bit_out(1'b1, 20);
    checks++;
    if (vcnt - v0 != 1) begin fails++; $display("FAIL parity_valid_count: got %0d, expected 1", vcnt - v0); end
    checks++;
    if (v_data !== F1) begin fails++; $display("FAIL parity_data: got %h, expected %h", v_data, F1); end
    checks++;
    if (v_perr !== 1'b1) begin fails++; $display("FAIL parity_flag: got %b, expected 1", v_perr); end
  endtask

  task automatic test_framing;
    int v0, f0;
    v0 = vcnt;
    f0 = fcnt;
    for (int k = 0; k < 6; k++) send_byte(F1[8*k +: 8], 1'b0, k != 5, BC);
    bit_out(1'b0, 15 * BC);
    checks++;
    if (fcnt - f0 != 1 || rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL ferr_pulse: got ferr=%0d busy=%b, expected 1 and 0", fcnt - f0, rx_busy);
    end
    bit_out(1'b0, 15 * BC);
    checks++;
    if (fcnt - f0 != 1 || vcnt != v0 || busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL ferr_break_hold: got ferr=%0d valid=%0d busy=%b, expected 1 0 0", fcnt - f0, vcnt - v0, rx_busy);
    end
    checks++;
    if (rx_data !== F1 || rx_perr !== 1'b1) begin
      fails++;
      $display("FAIL ferr_outputs_kept: got data=%h perr=%b, expected %h 1", rx_data, rx_perr, F1);
    end
    bit_out(1'b1, 2 * BC);
    send_frame(F2, -1, BC);
    bit_out(1'b1, 20);
    checks++;
    if (vcnt - v0 != 1 || v_data !== F2) begin
      fails++;
      $display("FAIL ferr_recover: got count=%0d data=%h, expected 1 %h", vcnt - v0, v_data, F2);
    end
    checks++;
    if (v_perr !== 1'b0) begin fails++; $display("FAIL perr_cleared: got %b, expected 0", v_perr); end
  endtask

  task automatic test_timeout;
    int v0, t0, c0;
    v0 = vcnt;
    t0 = tcnt;
    for (int k = 0; k < 4; k++) send_byte(F1[8*k +: 8], 1'b0, 1'b1, BC);
    c0 = cyc;
    bit_out(1'b1, 21 * BC);
    checks++;
    if (tcnt - t0 != 1 || vcnt != v0) begin
      fails++;
      $display("FAIL timeout_pulse: got tout=%0d valid=%0d, expected 1 0", tcnt - t0, vcnt - v0);
    end
    checks++;
    if (tout_cyc - c0 < 1600 || tout_cyc - c0 > 1760) begin
      fails++;
      $display("FAIL timeout_delay: got %0d cycles, expected 1600..1760", tout_cyc - c0);
    end
    checks++;
    if (rx_busy !== 1'b0 || rx_data !== F2) begin
      fails++;
      $display("FAIL timeout_state: got busy=%b data=%h, expected 0 %h", rx_busy, rx_data, F2);
    end
    send_frame(F3, -1, 84);
    bit_out(1'b1, 20);
    checks++;
    if (vcnt - v0 != 1 || v_data !== F3 || tcnt - t0 != 1) begin
      fails++;
      $display("FAIL timeout_next_frame_fast: got count=%0d data=%h tout=%0d, expected 1 %h 1", vcnt - v0, v_data, tcnt - t0, F3);
    end
  endtask

  task automatic test_glitch;
    int v0, f0, t0;
    v0 = vcnt;
    f0 = fcnt;
    t0 = tcnt;
    busy_seen = 1'b0;
    bit_out(1'b0, 20);
    bit_out(1'b1, 200);
    checks++;
    if (vcnt != v0 || fcnt != f0 || tcnt != t0 || busy_seen !== 1'b0) begin
      fails++;
      $display("FAIL glitch_reject: got v=%0d f=%0d t=%0d busy_seen=%b, expected 0 0 0 0", vcnt - v0, fcnt - f0, tcnt - t0, busy_seen);
    end
    send_frame(F2, -1, 88);
    bit_out(1'b1, 20);
    checks++;
    if (vcnt - v0 != 1 || v_data !== F2 || v_perr !== 1'b0) begin
      fails++;
      $display("FAIL slow_baud_frame: got count=%0d data=%h perr=%b, expected 1 %h 0", vcnt - v0, v_data, v_perr, F2);
    end
  endtask

  task automatic test_reset_mid;
    int v0, p0;
    logic [7:0] b;
    b = F3[23:16];
    for (int k = 0; k < 2; k++) send_byte(F3[8*k +: 8], 1'b0, 1'b1, BC);
    bit_out(1'b0, BC);
    for (int i = 0; i < 3; i++) bit_out(b[i], BC);
    bit_out(b[3], 40);
    checks++;
    if (rx_busy !== 1'b1) begin fails++; $display("FAIL midframe_busy: got %b, expected 1", rx_busy); end
    v0 = vcnt;
    p0 = vcnt + fcnt + tcnt;
    #10 rst = 1'b1;
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_perr, rx_ferr, rx_timeout, rx_busy} !== 69'd0) begin
      fails++;
      $display("FAIL async_reset: got data=%h busy=%b perr=%b, expected all 0", rx_data, rx_busy, rx_perr);
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    bit_out(1'b1, 3 * BC);
    checks++;
    if (vcnt + fcnt + tcnt != p0 || rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_pulses: got pulses=%0d busy=%b, expected 0 0", vcnt + fcnt + tcnt - p0, rx_busy);
    end
    send_frame(F1, -1, BC);
    bit_out(1'b1, 20);
    checks++;
    if (vcnt - v0 != 1 || v_data !== F1) begin
      fails++;
      $display("FAIL reset_recover: got count=%0d data=%h, expected 1 %h", vcnt - v0, v_data, F1);
    end
  endtask

  task automatic test_pulse_rules;
    checks++;
    if (viol != 0) begin fails++; $display("FAIL pulse_exclusive_single: got %0d violations, expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity();
    test_framing();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
